mmio_bus_ctrl: RTL

- Parametrised, registered successor to the team's combinational memory-mapped I/O decoder.
- Sits between the CPU data port and up to 16 peripheral/memory slaves.
- Decodes addr[31:28] into a slave index and runs a request/acknowledge transaction with variable wait states.
- Adds per-transaction timeout, error completion for unmapped regions, and a captured error address.

---
 rtl/mmio_bus_ctrl_if.sv | 30 +++
 rtl/mmio_bus_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mmio_bus_ctrl_if.sv
// rtl/mmio_bus_ctrl_if.sv - CPU-side and slave-side bus interfaces for mmio_bus_ctrl
// The CPU is master of mmio_cpu_if; the controller is master of mmio_slv_if.

interface mmio_cpu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, input ready, rdata, err);
  modport slave  (input req, we, addr, wdata, output ready, rdata, err);
endinterface

interface mmio_slv_if #(
  parameter int N_SLAVES = 8,
  parameter int SLV_AW   = 19
);
  logic [N_SLAVES-1:0]    sel;
  logic [N_SLAVES-1:0]    we;
  logic [SLV_AW-1:0]      addr;
  logic [31:0]            wdata;
  logic [32*N_SLAVES-1:0] rdata;
  logic [N_SLAVES-1:0]    ack;

  modport master (output sel, we, addr, wdata, input rdata, ack);
  modport slave  (input sel, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mmio_bus_ctrl.sv
// rtl/mmio_bus_ctrl.sv - registered MMIO decoder: addr[31:28] selects one of N_SLAVES
// Request/ack transactions with wait states, timeout, unmapped-error completion and error address capture.

module mmio_bus_ctrl #(
  parameter int          N_SLAVES = 8,
  parameter int          SLV_AW   = 19,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  mmio_cpu_if.slave         cpu,
  mmio_slv_if.master        slv,
  output logic [31:0]       err_addr,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [4:0] N_SL = 5'(N_SLAVES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        err_addr_q, err_addr_d;

  logic               ack_hit;
  logic [31:0]        sel_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Only the selected slave's ack and read data are looked at; stray acks fall out here.
  always_comb begin
    ack_hit   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (idx_q == 4'(i)) begin
        ack_hit   = slv.ack[i];
        sel_rdata = slv.rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (cpu.req) begin
          idx_d   = cpu.addr[31:28];
          we_d    = cpu.we;
          addr_d  = cpu.addr;
          wdata_d = cpu.wdata;
          cnt_d   = '0;
          if ({1'b0, cpu.addr[31:28]} < N_SL) begin
            state_d = ACCESS;
          end else begin
            state_d    = DONE;
            ready_d    = 1'b1;
            err_d      = 1'b1;
            rdata_d    = ERR_DATA;
            err_addr_d = cpu.addr;
          end
        end
      end
      ACCESS: begin
        if (ack_hit) begin
          state_d = DONE;
          ready_d = 1'b1;
          rdata_d = we_q ? 32'h0 : sel_rdata;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d    = DONE;
          ready_d    = 1'b1;
          err_d      = 1'b1;
          rdata_d    = ERR_DATA;
          err_addr_d = addr_q;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    slv.sel = '0;
    slv.we  = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if ((state_q == ACCESS) && (idx_q == 4'(i))) begin
        slv.sel[i] = 1'b1;
        slv.we[i]  = we_q;
      end
    end
    slv.addr  = addr_q[SLV_AW+1:2];
    slv.wdata = wdata_q;
    cpu.ready = ready_q;
    cpu.err   = err_q;
    cpu.rdata = rdata_q;
    err_addr  = err_addr_q;
    busy      = (state_q != IDLE);
  end

endmodule
